dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences every data-memory access issued by the MEM stage onto a single-port,
//  multi-cycle SRAM. Holds the pipeline with `freeze` until the access completes.
//  Sits between EXE2MEM outputs (MEM_R_EN, MEM_W_EN, ALU_res, ST_value) and MEM2WB (dataMem_out).
//  Optionally arbitrates the SRAM between the pipeline and a program/data loader port.
// PARAMETERS
//  WAIT_CYCLES    2     SRAM cycles per access (>=1); ce held for exactly this many cycles
//  ADDR_OFFSET    1024  byte base of data space; subtracted from ALU_res
//  SRAM_ADDR_LEN  17    SRAM word-address width
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              synchronous, active-high reset
//  MEM_R_EN     in   1              MEM-stage load request
//  MEM_W_EN     in   1              MEM-stage store request
//  ALU_res      in   WORD_LEN       byte address from EXE2MEM
//  ST_value     in   WORD_LEN       store data
//  dataMem_out  out  WORD_LEN       registered load data to MEM2WB
//  freeze       out  1              stall to IF/ID/EXE/MEM pipeline registers
//  sram_addr    out  SRAM_ADDR_LEN  word address
//  sram_wdata   out  WORD_LEN       write data
//  sram_rdata   in   WORD_LEN       read data, valid during last ACCESS cycle
//  sram_ce      out  1              chip enable, high throughout ACCESS
//  sram_we      out  1              write enable, high throughout ACCESS for writes
//  ld_req/ld_we in   1 each         loader request / write (DMEM_LOADER_ARB_EN only)
//  ld_addr      in   SRAM_ADDR_LEN  loader word address (macro only)
//  ld_wdata     in   WORD_LEN       loader write data (macro only)
//  ld_gnt/ld_done out 1 each        grant pulse at launch / done pulse at DONE (macro only)
//  ld_rdata     out  WORD_LEN       loader read data, valid with ld_done (macro only)
// BEHAVIOUR
//  - FSM IDLE -> ACCESS -> DONE -> IDLE. Owner (PIPE/LDR) latched on IDLE exit.
//  - IDLE: pipe_req = MEM_R_EN|MEM_W_EN. Launch: latch addr/data/we, cnt=WAIT_CYCLES-1.
//  - ACCESS: sram_ce=1. Decrement each cycle; at cnt==0 capture sram_rdata (reads only)
//    into dataMem_out or ld_rdata, go DONE.
//  - DONE: one cycle. Always returns to IDLE. Never relaunches. The instruction advancing
//    on this edge is not re-serviced.
//  - freeze = pipe_req & ~(state==DONE & owner==PIPE). freeze is combinational from the
//    registered state and the inputs. WAIT_CYCLES=2 load: freeze high 3 cycles, low on the
//    4th with dataMem_out valid.
//  - Address: sram_addr = (ALU_res - ADDR_OFFSET) >> 2, truncated. Bits [1:0] are ignored.
//  - MEM_R_EN & MEM_W_EN both high: performed as a write; dataMem_out holds its prior value.
//  - Write: dataMem_out is unchanged.
//  - Request inputs are sampled only in IDLE. Changes during ACCESS/DONE are ignored.
//  - Reset (at any time, including mid-ACCESS): state IDLE, owner PIPE.
//    Reset values: cnt 0, dataMem_out 0, sram_addr 0, sram_wdata 0, sram_ce 0, sram_we 0,
//    freeze 0, ld_gnt 0, ld_done 0, ld_rdata 0, last_grant PIPE.
//    The aborted access is lost and is not retried.
// CONFIGURATION
//  DMEM_LOADER_ARB_EN defined: loader port present.
//  - Round-robin arbitration in IDLE:
//    - Both requesting: the side opposite last_grant wins.
//    - A single requester wins.
//  - While the loader owns the SRAM, a pipeline request keeps freeze high.
//  - ld_gnt pulses for 1 cycle at launch. ld_done pulses in DONE.
//  - The loader holds ld_req/ld_addr/ld_wdata until ld_gnt.
//  DMEM_LOADER_ARB_EN undefined: ld_* ports absent; the pipeline is the only requester.
// STRUCTURE
//  - defines.v: WORD_LEN, DMEM_ST_IDLE/ACCESS/DONE, DMEM_ST_LEN, DMEM_OWN_PIPE/LDR.
//  - Sub-module dmem_wait_counter: load value, decrement enable, zero flag.
//  - FSM, address mapping and arbitration stay in dmem_access_ctrl.
// TESTING
//  1. Store at ALU_res=1032, ST_value=0xDEADBEEF, WAIT_CYCLES=2
//     -> sram_addr=2, sram_we=1 for 2 cycles, freeze 1,1,1,0.
//  2. Load from 1032 on the next instruction, SRAM returns 0xDEADBEEF
//     -> dataMem_out=0xDEADBEEF in the freeze-low cycle. No second access launched.
//  3. Back-to-back loads 1024, 1028
//     -> exactly 2 launches, freeze pattern 1,1,1,0,1,1,1,0.
//  4. rst asserted in the 2nd ACCESS cycle
//     -> next cycle: sram_ce=0, freeze=0, dataMem_out=0, state IDLE.
//  5. MEM_R_EN=MEM_W_EN=1 -> write performed, dataMem_out unchanged.
//  6. (macro) ld_req and a pipe load together, last_grant=PIPE
//     -> loader served first with freeze held high; the pipe load completes after it.
//     Then a loader write to addr 5 -> ld_done pulse, sram_addr=5.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared types, widths and address helper for the data-memory access controller
// Used by dmem_access_ctrl; the loader port is enabled with DMEM_LOADER_ARB_EN.
package dmem_access_ctrl_pkg;

  localparam int WORD_LEN    = 32;
  localparam int DMEM_ST_LEN = 2;

  typedef enum logic [DMEM_ST_LEN-1:0] {
    DMEM_ST_IDLE   = 2'd0,
    DMEM_ST_ACCESS = 2'd1,
    DMEM_ST_DONE   = 2'd2
  } dmem_state_e;

  typedef enum logic {
    DMEM_OWN_PIPE = 1'b0,
    DMEM_OWN_LDR  = 1'b1
  } dmem_owner_e;

  // Byte address relative to the data-space base, converted to a word index.
  function automatic logic [WORD_LEN-1:0] dmem_word_index(
    input logic [WORD_LEN-1:0] byte_addr,
    input logic [WORD_LEN-1:0] base
  );
    return (byte_addr - base) >> 2;
  endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// rtl/dmem_wait_counter.sv - SRAM wait-state down counter with load, decrement enable and zero flag
// Saturates at zero so a stray decrement cannot wrap.
module dmem_wait_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - sequences MEM-stage loads/stores onto a single-port multi-cycle SRAM
// Define DMEM_LOADER_ARB_EN to add a round-robin arbitrated loader port.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES   = 2,
  parameter int ADDR_OFFSET   = 1024,
  parameter int SRAM_ADDR_LEN = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MEM_R_EN,
  input  logic                     MEM_W_EN,
  input  logic [WORD_LEN-1:0]      ALU_res,
  input  logic [WORD_LEN-1:0]      ST_value,
  output logic [WORD_LEN-1:0]      dataMem_out,
  output logic                     freeze,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [WORD_LEN-1:0]      sram_wdata,
  input  logic [WORD_LEN-1:0]      sram_rdata,
  output logic                     sram_ce,
  output logic                     sram_we
`ifdef DMEM_LOADER_ARB_EN
  ,
  input  logic                     ld_req,
  input  logic                     ld_we,
  input  logic [SRAM_ADDR_LEN-1:0] ld_addr,
  input  logic [WORD_LEN-1:0]      ld_wdata,
  output logic                     ld_gnt,
  output logic                     ld_done,
  output logic [WORD_LEN-1:0]      ld_rdata
`endif
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  dmem_state_e              r_state;
  dmem_owner_e              r_owner;
  logic [WORD_LEN-1:0]      r_data_out;
  logic [SRAM_ADDR_LEN-1:0] r_sram_addr;
  logic [WORD_LEN-1:0]      r_sram_wdata;
  logic                     r_sram_ce;
  logic                     r_sram_we;

  logic                     w_pipe_req;
  logic                     w_launch;
  dmem_owner_e              w_launch_owner;
  logic [SRAM_ADDR_LEN-1:0] w_launch_addr;
  logic [WORD_LEN-1:0]      w_launch_wdata;
  logic                     w_launch_we;
  logic                     w_idle_launch;
  logic                     w_cnt_zero;

  assign w_pipe_req = MEM_R_EN | MEM_W_EN;

`ifdef DMEM_LOADER_ARB_EN
  dmem_owner_e         r_last_grant;
  logic                r_ld_gnt;
  logic                r_ld_done;
  logic [WORD_LEN-1:0] r_ld_rdata;

  // On contention the side that did not win last time goes first.
  always_comb begin
    w_launch       = w_pipe_req | ld_req;
    w_launch_owner = DMEM_OWN_PIPE;
    if (w_pipe_req && ld_req) begin
      w_launch_owner = (r_last_grant == DMEM_OWN_PIPE) ? DMEM_OWN_LDR : DMEM_OWN_PIPE;
    end else if (ld_req) begin
      w_launch_owner = DMEM_OWN_LDR;
    end
  end

  assign ld_gnt   = r_ld_gnt;
  assign ld_done  = r_ld_done;
  assign ld_rdata = r_ld_rdata;
`else
  assign w_launch       = w_pipe_req;
  assign w_launch_owner = DMEM_OWN_PIPE;
`endif

  // A simultaneous read+write request is performed as a write.
  always_comb begin
    w_launch_addr  = SRAM_ADDR_LEN'(dmem_word_index(ALU_res, WORD_LEN'(ADDR_OFFSET)));
    w_launch_wdata = ST_value;
    w_launch_we    = MEM_W_EN;
`ifdef DMEM_LOADER_ARB_EN
    if (w_launch_owner == DMEM_OWN_LDR) begin
      w_launch_addr  = ld_addr;
      w_launch_wdata = ld_wdata;
      w_launch_we    = ld_we;
    end
`endif
  end

  assign w_idle_launch = (r_state == DMEM_ST_IDLE) && w_launch;

  dmem_wait_counter #(
    .CNT_W(CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_idle_launch),
    .i_load_val (CNT_W'(WAIT_CYCLES - 1)),
    .i_dec      (r_state == DMEM_ST_ACCESS),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= DMEM_ST_IDLE;
      r_owner      <= DMEM_OWN_PIPE;
      r_data_out   <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_sram_ce    <= 1'b0;
      r_sram_we    <= 1'b0;
`ifdef DMEM_LOADER_ARB_EN
      r_last_grant <= DMEM_OWN_PIPE;
      r_ld_gnt     <= 1'b0;
      r_ld_done    <= 1'b0;
      r_ld_rdata   <= '0;
`endif
    end else begin
`ifdef DMEM_LOADER_ARB_EN
      r_ld_gnt  <= 1'b0;
      r_ld_done <= 1'b0;
`endif
      unique case (r_state)
        DMEM_ST_IDLE: begin
          if (w_launch) begin
            r_state      <= DMEM_ST_ACCESS;
            r_owner      <= w_launch_owner;
            r_sram_addr  <= w_launch_addr;
            r_sram_wdata <= w_launch_wdata;
            r_sram_we    <= w_launch_we;
            r_sram_ce    <= 1'b1;
`ifdef DMEM_LOADER_ARB_EN
            r_last_grant <= w_launch_owner;
            r_ld_gnt     <= (w_launch_owner == DMEM_OWN_LDR);
`endif
          end
        end
        DMEM_ST_ACCESS: begin
          if (w_cnt_zero) begin
            r_state   <= DMEM_ST_DONE;
            r_sram_ce <= 1'b0;
            r_sram_we <= 1'b0;
`ifdef DMEM_LOADER_ARB_EN
            r_ld_done <= (r_owner == DMEM_OWN_LDR);
            if (!r_sram_we && (r_owner == DMEM_OWN_LDR)) begin
              r_ld_rdata <= sram_rdata;
            end
`endif
            if (!r_sram_we && (r_owner == DMEM_OWN_PIPE)) begin
              r_data_out <= sram_rdata;
            end
          end
        end
        // The instruction leaving on this edge must not be re-serviced.
        DMEM_ST_DONE: begin
          r_state <= DMEM_ST_IDLE;
        end
        default: begin
          r_state <= DMEM_ST_IDLE;
        end
      endcase
    end
  end

  assign freeze = ~rst & w_pipe_req &
                  ~((r_state == DMEM_ST_DONE) && (r_owner == DMEM_OWN_PIPE));

  assign dataMem_out = r_data_out;
  assign sram_addr   = r_sram_addr;
  assign sram_wdata  = r_sram_wdata;
  assign sram_ce     = r_sram_ce;
  assign sram_we     = r_sram_we;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
// Loader steps run only when DMEM_LOADER_ARB_EN is defined.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_res;
  logic [31:0] ST_value;
  logic [31:0] dataMem_out;
  logic        freeze;
  logic [16:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ce;
  logic        sram_we;
`ifdef DMEM_LOADER_ARB_EN
  logic        ld_req;
  logic        ld_we;
  logic [16:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_done;
  logic [31:0] ld_rdata;
`endif

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_access_ctrl #(
    .WAIT_CYCLES   (2),
    .ADDR_OFFSET   (1024),
    .SRAM_ADDR_LEN (17)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .ALU_res     (ALU_res),
    .ST_value    (ST_value),
    .dataMem_out (dataMem_out),
    .freeze      (freeze),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .sram_ce     (sram_ce),
    .sram_we     (sram_we)
`ifdef DMEM_LOADER_ARB_EN
    ,
    .ld_req      (ld_req),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata),
    .ld_gnt      (ld_gnt),
    .ld_done     (ld_done),
    .ld_rdata    (ld_rdata)
`endif
  );

  // SRAM model: preloaded with A500_00ii during reset, written while ce&we.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (sram_ce && sram_we) begin
      mem[sram_addr[7:0]] <= sram_wdata;
    end
  end

  assign sram_rdata = (sram_ce && !sram_we) ? mem[sram_addr[7:0]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int         launches;
    int         k;
    logic       prev_ce;

    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_res = 32'd0; ST_value = 32'd0;
`ifdef DMEM_LOADER_ARB_EN
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = 32'd0;
`endif
    tick(); tick(); #1;
    chkb("rst_freeze", freeze, 1'b0);
    chkb("rst_ce", sram_ce, 1'b0);
    chkb("rst_we", sram_we, 1'b0);
    chk("rst_dout", dataMem_out, 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_wdata", sram_wdata, 32'h0);
    rst = 1'b0;

    // Store 0xDEADBEEF to byte 1032 -> word 2
    tick(); MEM_W_EN = 1'b1; ALU_res = 32'd1032; ST_value = 32'hDEADBEEF; #1;
    chkb("st_frz0", freeze, 1'b1);
    tick(); #1;
    chkb("st_ce1", sram_ce, 1'b1);
    chkb("st_we1", sram_we, 1'b1);
    chk("st_addr", 32'(sram_addr), 32'd2);
    chk("st_wdata", sram_wdata, 32'hDEADBEEF);
    chkb("st_frz1", freeze, 1'b1);
    tick(); #1;
    chkb("st_ce2", sram_ce, 1'b1);
    chkb("st_we2", sram_we, 1'b1);
    chkb("st_frz2", freeze, 1'b1);
    tick(); #1;
    chkb("st_frz3", freeze, 1'b0);
    chkb("st_ce3", sram_ce, 1'b0);
    chkb("st_we3", sram_we, 1'b0);

    // Load it back
    tick(); MEM_W_EN = 1'b0; MEM_R_EN = 1'b1; #1;
    chkb("ld_frz0", freeze, 1'b1);
    tick(); #1;
    chkb("ld_ce1", sram_ce, 1'b1);
    chkb("ld_we1", sram_we, 1'b0);
    chk("ld_addr", 32'(sram_addr), 32'd2);
    tick(); #1;
    tick(); #1;
    chkb("ld_frz3", freeze, 1'b0);
    chk("ld_dout", dataMem_out, 32'hDEADBEEF);
    tick(); MEM_R_EN = 1'b0; #1;
    chkb("ld_no_relaunch", sram_ce, 1'b0);
    chkb("ld_idle_frz", freeze, 1'b0);

    // Back-to-back loads 1024, 1028
    pat = 8'h0; launches = 0; k = 0; prev_ce = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      MEM_R_EN = (k < 2);
      ALU_res  = 32'd1024 + 32'(4 * k);
      #1;
      pat = {pat[6:0], freeze};
      if (sram_ce && !prev_ce) launches++;
      prev_ce = sram_ce;
      if (!freeze && k < 2) begin
        chk("b2b_dout", dataMem_out, (k == 0) ? 32'hA500_0000 : 32'hA500_0001);
        k++;
      end
    end
    chk("b2b_freeze_pat", 32'(pat), 32'h0000_00EE);
    chk("b2b_launches", 32'(launches), 32'd2);
    chk("b2b_completed", 32'(k), 32'd2);

    // Reset during the 2nd ACCESS cycle
    tick(); MEM_R_EN = 1'b1; ALU_res = 32'd1024; #1;
    tick(); #1;
    chkb("rsta_ce1", sram_ce, 1'b1);
    tick(); rst = 1'b1; MEM_R_EN = 1'b0; #1;
    tick(); rst = 1'b0; #1;
    chkb("rsta_ce", sram_ce, 1'b0);
    chkb("rsta_we", sram_we, 1'b0);
    chkb("rsta_frz", freeze, 1'b0);
    chk("rsta_dout", dataMem_out, 32'h0);
    MEM_R_EN = 1'b1; ALU_res = 32'd1028; #1;
    chkb("rsta_relaunch_frz", freeze, 1'b1);
    tick(); #1;
    chkb("rsta_relaunch_ce", sram_ce, 1'b1);
    chk("rsta_relaunch_addr", 32'(sram_addr), 32'd1);
    tick(); #1;
    tick(); #1;
    chkb("rsta_done_frz", freeze, 1'b0);
    chk("rsta_done_dout", dataMem_out, 32'hA500_0001);

    // Read and write together -> write, dataMem_out held
    tick(); MEM_R_EN = 1'b1; MEM_W_EN = 1'b1; ALU_res = 32'd1036; ST_value = 32'hCAFEF00D; #1;
    chkb("rw_frz0", freeze, 1'b1);
    tick(); #1;
    chkb("rw_we", sram_we, 1'b1);
    chk("rw_addr", 32'(sram_addr), 32'd3);
    tick(); #1;
    tick(); #1;
    chkb("rw_frz3", freeze, 1'b0);
    chk("rw_dout_held", dataMem_out, 32'hA500_0001);
    tick(); MEM_W_EN = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    tick(); #1;
    chkb("rw_rd_frz", freeze, 1'b0);
    chk("rw_rd_dout", dataMem_out, 32'hCAFEF00D);
    tick(); MEM_R_EN = 1'b0; #1;

`ifdef DMEM_LOADER_ARB_EN
    // Loader and pipe load together, last grant PIPE -> loader first
    tick(); ld_req = 1'b1; ld_we = 1'b0; ld_addr = 17'd4; MEM_R_EN = 1'b1; ALU_res = 32'd1024; #1;
    chkb("arb_frz0", freeze, 1'b1);
    tick(); ld_req = 1'b0; #1;
    chkb("arb_gnt", ld_gnt, 1'b1);
    chk("arb_ld_addr", 32'(sram_addr), 32'd4);
    chkb("arb_frz1", freeze, 1'b1);
    tick(); #1;
    chkb("arb_gnt_pulse", ld_gnt, 1'b0);
    chkb("arb_frz2", freeze, 1'b1);
    tick(); #1;
    chkb("arb_ld_done", ld_done, 1'b1);
    chk("arb_ld_rdata", ld_rdata, 32'hA500_0004);
    chkb("arb_frz3", freeze, 1'b1);
    tick(); #1;
    chkb("arb_done_pulse", ld_done, 1'b0);
    chkb("arb_frz4", freeze, 1'b1);
    tick(); #1;
    chkb("arb_pipe_ce", sram_ce, 1'b1);
    chk("arb_pipe_addr", 32'(sram_addr), 32'd0);
    chkb("arb_pipe_no_gnt", ld_gnt, 1'b0);
    tick(); #1;
    tick(); #1;
    chkb("arb_pipe_frz", freeze, 1'b0);
    chk("arb_pipe_dout", dataMem_out, 32'hA500_0000);

    // Loader write to word 5
    tick(); MEM_R_EN = 1'b0; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 17'd5; ld_wdata = 32'h55AA55AA; #1;
    chkb("ldw_frz", freeze, 1'b0);
    tick(); ld_req = 1'b0; #1;
    chkb("ldw_gnt", ld_gnt, 1'b1);
    chkb("ldw_we", sram_we, 1'b1);
    chk("ldw_addr", 32'(sram_addr), 32'd5);
    chk("ldw_wdata", sram_wdata, 32'h55AA55AA);
    tick(); #1;
    tick(); #1;
    chkb("ldw_done", ld_done, 1'b1);
    tick(); #1;
    chkb("ldw_done_pulse", ld_done, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
